// File: rtl/smallcalc_rf_pkg.sv
// Shared types and default sizes for the smallcalc register file.
package smallcalc_rf_pkg;

  localparam int unsigned DW_DEF = 5;
  localparam int unsigned AW_DEF = 2;

  typedef enum logic [0:0] {
    IDLE,
    CLEAR
  } state_e;

endpackage

// File: rtl/smallcalc_rf_clr_fsm.sv
// Clear sequencer: sweeps a zero write across every entry after reset or a clr request.
module smallcalc_rf_clr_fsm
  import smallcalc_rf_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        // Last entry written this cycle; pointer wraps back to 0.
        if (&ptr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == CLEAR);
    clr_we   = busy;
    clr_addr = ptr_q;
  end

endmodule

// File: rtl/smallcalc_regfile.sv
// Two-read, one-write register file with registered reads and a sweeping clear.
// Define SMALLCALC_RF_BYPASS_EN for write-first reads on an address collision.
module smallcalc_regfile
  import smallcalc_rf_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          rea,
  input  logic          reb,
  input  logic [AW-1:0] raa,
  input  logic [AW-1:0] rab,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] douta,
  output logic [DW-1:0] doutb,
  output logic          busy
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] douta_q, douta_d, doutb_q, doutb_d;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  smallcalc_rf_clr_fsm #(
    .AW(AW)
  ) u_clr_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // The sweep owns the write port while busy; reset blocks all writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wa;
    wr_data = din;
    if (!rst) begin
      if (clr_we) begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        wr_data = '0;
      end else begin
        wr_en = we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    douta_d = '0;
    doutb_d = '0;
    if (!busy) begin
      if (rea) douta_d = mem_q[raa];
      if (reb) doutb_d = mem_q[rab];
`ifdef SMALLCALC_RF_BYPASS_EN
      if (rea && we && (raa == wa)) douta_d = din;
      if (reb && we && (rab == wa)) doutb_d = din;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
    end
  end

  assign douta = douta_q;
  assign doutb = doutb_q;

endmodule

// File: tb/tb_smallcalc_regfile.sv
// Directed bench for smallcalc_regfile: default instance plus an 8-bit, 16-entry instance.
module tb_smallcalc_regfile;

`ifdef SMALLCALC_RF_BYPASS_EN
  localparam logic Byp = 1'b1;
`else
  localparam logic Byp = 1'b0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       rst, clr, rea, reb, we;
  logic [1:0] raa, rab, wa;
  logic [4:0] din, douta, doutb;
  logic       busy;

  smallcalc_regfile u_dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .rea  (rea),
    .reb  (reb),
    .raa  (raa),
    .rab  (rab),
    .we   (we),
    .wa   (wa),
    .din  (din),
    .douta(douta),
    .doutb(doutb),
    .busy (busy)
  );

  // Wide instance
  logic       rst_w, clr_w, rea_w, reb_w, we_w;
  logic [3:0] raa_w, rab_w, wa_w;
  logic [7:0] din_w, douta_w, doutb_w;
  logic       busy_w;

  smallcalc_regfile #(
    .DW(8),
    .AW(4)
  ) u_dut_w (
    .clk  (clk),
    .rst  (rst_w),
    .clr  (clr_w),
    .rea  (rea_w),
    .reb  (reb_w),
    .raa  (raa_w),
    .rab  (rab_w),
    .we   (we_w),
    .wa   (wa_w),
    .din  (din_w),
    .douta(douta_w),
    .doutb(doutb_w),
    .busy (busy_w)
  );

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [4:0] din;
    logic       rea;
    logic [1:0] raa;
    logic       reb;
    logic [1:0] rab;
    logic [4:0] exp_a;
    logic [4:0] exp_b;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; rea = 0; reb = 0; we = 0;
    raa = 0; rab = 0; wa = 0; din = 0;
  endtask

  task automatic write(input logic [1:0] a, input logic [4:0] d);
    we = 1; wa = a; din = d;
    step();
    we = 0;
  endtask

  task automatic read_both(input string name, input logic [1:0] a, input logic [4:0] exp);
    rea = 1; raa = a; reb = 1; rab = a;
    step();
    chk({name, "_a"}, 32'(douta), 32'(exp));
    chk({name, "_b"}, 32'(doutb), 32'(exp));
    rea = 0; reb = 0;
  endtask

  // Counts edges until busy drops (bounded).
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      step();
      cnt++;
    end
  endtask

  vec_t vecs[10];
  int   cnt;

  initial begin
    idle_inputs();
    rst = 1;
    rst_w = 1; clr_w = 0; rea_w = 0; reb_w = 0; we_w = 0;
    raa_w = 0; rab_w = 0; wa_w = 0; din_w = 0;

    // Reset: one-cycle pulse
    step();
    chk("rst_douta", 32'(douta), 0);
    chk("rst_doutb", 32'(doutb), 0);
    chk("rst_busy", 32'(busy), 1);
    rst = 0;
    count_busy(cnt);
    chk("rst_busy_cycles", cnt, 4);
    for (int i = 0; i < 4; i++) read_both("rst_read", 2'(i), 5'h00);

    // Single-cycle vectors
    vecs[0] = '{0, 0, 0,     1, 0, 1, 1, 5'h00, 5'h00};
    vecs[1] = '{1, 2, 5'h1A, 0, 0, 0, 0, 5'h00, 5'h00};
    vecs[2] = '{0, 0, 0,     1, 2, 1, 2, 5'h1A, 5'h1A};
    vecs[3] = '{0, 0, 0,     0, 2, 1, 2, 5'h00, 5'h1A};
    vecs[4] = '{1, 0, 5'h05, 1, 0, 1, 3, Byp ? 5'h05 : 5'h00, 5'h00};
    vecs[5] = '{1, 1, 5'h03, 1, 0, 1, 2, 5'h05, 5'h1A};
    vecs[6] = '{1, 1, 5'h1F, 1, 1, 1, 2, Byp ? 5'h1F : 5'h03, 5'h1A};
    vecs[7] = '{0, 0, 0,     1, 1, 1, 1, 5'h1F, 5'h1F};
    vecs[8] = '{1, 3, 5'h15, 1, 3, 1, 0, Byp ? 5'h15 : 5'h00, 5'h05};
    vecs[9] = '{1, 3, 5'h0C, 1, 0, 1, 3, 5'h05, Byp ? 5'h0C : 5'h15};
    for (int i = 0; i < 10; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; din = vecs[i].din;
      rea = vecs[i].rea; raa = vecs[i].raa; reb = vecs[i].reb; rab = vecs[i].rab;
      step();
      chk($sformatf("vec%0d_a", i), 32'(douta), 32'(vecs[i].exp_a));
      chk($sformatf("vec%0d_b", i), 32'(doutb), 32'(vecs[i].exp_b));
    end
    idle_inputs();

    // Clear sweep with writes and reads attempted during it
    for (int i = 0; i < 4; i++) write(2'(i), 5'h15);
    clr = 1;
    step();
    chk("clr_busy_start", 32'(busy), 1);
    we = 1; wa = 3; din = 5'h07;
    rea = 1; raa = 3; reb = 1; rab = 0;
    cnt = 0;
    while (busy && cnt < 40) begin
      clr = (cnt < 2);
      step();
      chk("sweep_douta", 32'(douta), 0);
      chk("sweep_doutb", 32'(doutb), 0);
      cnt++;
    end
    chk("clr_busy_cycles", cnt, 4);
    idle_inputs();
    for (int i = 0; i < 4; i++) read_both("post_clr", 2'(i), 5'h00);

    // Reset on the third sweep cycle
    write(2, 5'h0A);
    write(1, 5'h0B);
    clr = 1;
    step();
    clr = 0;
    step();
    step();
    rst = 1;
    step();
    chk("midrst_busy", 32'(busy), 1);
    rst = 0;
    count_busy(cnt);
    chk("midrst_busy_cycles", cnt, 4);
    read_both("midrst_e1", 1, 5'h00);
    read_both("midrst_e2", 2, 5'h00);

    // Wide instance: 16-entry sweep
    step();
    rst_w = 0;
    cnt = 0;
    while (busy_w && cnt < 80) begin
      step();
      cnt++;
    end
    chk("wide_busy_cycles", cnt, 16);
    we_w = 1; wa_w = 15; din_w = 8'hA5;
    step();
    we_w = 0;
    rea_w = 1; raa_w = 15; reb_w = 1; rab_w = 15;
    step();
    chk("wide_read_a", 32'(douta_w), 32'h00A5);
    chk("wide_read_b", 32'(doutb_w), 32'h00A5);
    raa_w = 0; rab_w = 14;
    step();
    chk("wide_read0_a", 32'(douta_w), 0);
    chk("wide_read14_b", 32'(doutb_w), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/smallcalc_regfile.md
SMALLCALC_REGFILE -- requirements
Module: smallcalc_regfile

Interface
REQ-001 Parameter DW, default 5: data width in bits, 1..32.
REQ-002 Parameter AW, default 2: address width; depth DEPTH = 2**AW entries.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 clr  input  1  single-cycle request to zero every entry.
REQ-007 rea, reb  input  1 each  read enables, ports A and B.
REQ-008 raa, rab  input  AW each  read addresses, ports A and B.
REQ-009 we  input  1  write enable.
REQ-010 wa  input  AW  write address.
REQ-011 din  input  DW  write data.
REQ-012 douta, doutb  output  DW each  registered read data, ports A and B.
REQ-013 busy  output  1  high while the clear sweep runs.

Function
REQ-014 Reads SHALL have one-cycle latency: with rea=1 at edge N, douta after edge N equals entry[raa]; with rea=0, douta becomes 0; port B behaves identically.
REQ-015 A write with we=1 SHALL update entry[wa] with din at the edge; with we=0, no entry changes.
REQ-016 The FSM SHALL have two states, IDLE and CLEAR, and a sweep pointer of width AW.
REQ-017 In IDLE, clr=1 SHALL go to CLEAR with pointer 0 and busy=1 from the next cycle.
REQ-018 In CLEAR, each cycle SHALL write 0 to entry[pointer] and increment the pointer; the cycle that writes DEPTH-1 SHALL return to IDLE, with busy=0 from the next cycle; a sweep lasts exactly DEPTH cycles.
REQ-019 In CLEAR, we and clr SHALL be ignored, and douta and doutb SHALL load 0 regardless of rea and reb.
REQ-020 Reads and writes SHALL be fully parallel: both ports may read the same address, including wa, in the same cycle.
REQ-021 Out-of-range addresses cannot occur (depth is exactly 2**AW); the pointer wraps naturally and has no undefined values.

Reset
REQ-022 rst=1 SHALL force state CLEAR, pointer 0, douta=0, doutb=0 and busy=1 at the next edge, so every entry is zero DEPTH cycles after rst is released.
REQ-023 rst asserted during a sweep SHALL restart the sweep at pointer 0; rst overrides clr, we and the read enables.
REQ-024 Entry contents SHALL NOT be reset directly, only through the sweep.

Configuration
REQ-025 Macro SMALLCALC_RF_BYPASS_EN defined: in IDLE, a read with we=1 and the read address equal to wa SHALL return din (write-first).
REQ-026 Macro undefined: such a read SHALL return the entry's previous contents (read-first).

Structure
REQ-027 Package smallcalc_rf_pkg SHALL hold the state enum (IDLE, CLEAR) and default constants DW_DEF=5 and AW_DEF=2.
REQ-028 The clear FSM and pointer SHALL be sub-module smallcalc_rf_clr_fsm (outputs busy, clr_we, clr_addr); the storage array and read logic stay in the top level.

Verification
REQ-029 Reset: pulse rst for 1 cycle, defaults -> busy=1 for exactly 4 cycles; then read all 4 addresses on both ports -> 0.
REQ-030 Write/read: write 5'h1A to addr 2, then rea=1, raa=2 and reb=1, rab=2 -> both ports show 5'h1A one cycle later; rea=0 -> douta=0 next cycle.
REQ-031 Same-cycle collision: entry 1 = 5'h03; we=1, wa=1, din=5'h1F with rea=1, raa=1 -> douta=5'h1F with SMALLCALC_RF_BYPASS_EN defined, 5'h03 without; entry 1 = 5'h1F afterwards in both builds.
REQ-032 Clear: fill all entries with 5'h15, pulse clr -> busy=1 for 4 cycles; we=1, wa=3, din=5'h07 during the sweep is dropped; reads during the sweep return 0; all entries read 0 afterwards.
REQ-033 Reset mid-sweep: assert rst on the 3rd sweep cycle -> pointer restarts at 0 and busy stays high 4 more cycles after rst falls.
REQ-034 Parameter sweep: DW=8, AW=4 -> 16-cycle clear; write 8'hA5 to addr 15 -> reads back 8'hA5.
